gnn_run_ctrl: RTL and testbench

Job controller and round-robin arbiter that shares one GNN inference core among `N_REQ` requesters. It grants one requester at a time and drives `sel` so an external operand mux routes that requester's node features and weights to the core. It raises the core's `in_ready`, waits for all eight output-ready flags or a timeout, and captures the eight 21-bit results into a response register. It then enforces a mandatory `in_ready`-low gap before the next job.

---
 rtl/gnn_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_gnn_run_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_run_ctrl.sv
// gnn_run_ctrl: round-robin job controller sharing one GNN inference core.
// Grants one requester per job, drives the operand mux select, holds the
// core's in_ready through RUN, captures the eight result slices (or flags a
// timeout), presents them as a response and enforces an in_ready-low gap
// before the next job can start.
module gnn_run_ctrl #(
    parameter  int N_REQ   = 4,
    parameter  int OUT_W   = 21,
    parameter  int TIMEOUT = 31,
    parameter  int GAP     = 5,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic [N_REQ-1:0]     gnt,
    output logic [IDW-1:0]       sel,
    output logic                 core_in_ready,
    input  logic [7:0]           core_out_ready,
    input  logic [8*OUT_W-1:0]   core_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [8*OUT_W-1:0]   rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    // Counter widths: run counter must hold TIMEOUT, gap counter GAP-1.
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int SW = IDW + 1;
    localparam int DW = 8 * OUT_W;

    localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [GW-1:0]  GAP_LOAD  = GW'(GAP - 1);
    localparam logic [IDW-1:0] LAST_IDX  = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   run_cnt_reg;
    logic [GW-1:0]   gap_cnt_reg;
    logic [IDW-1:0]  rr_ptr_reg;

    // ------------------------------------------------------------------
    // Round-robin search. Candidate gi is the requester at distance gi
    // above rr_ptr (with wrap); the lowest distance with a request wins.
    // ------------------------------------------------------------------
    logic [IDW-1:0]   cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;
    logic [N_REQ-1:0] pick_onehot;
    logic [IDW-1:0]   rr_ptr_next;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum           = {1'b0, rr_ptr_reg} + SW'(gi);
            assign cand_idx[gi]  = (sum >= SW'(N_REQ)) ? IDW'(sum - SW'(N_REQ))
                                                       : sum[IDW-1:0];
            assign cand_hit[gi]  = req[cand_idx[gi]];
        end
    endgenerate

    // Priority pick: walk from the farthest candidate down so the nearest wins.
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                pick_idx = cand_idx[i];
            end
        end
    end

    assign pick_any    = |req;
    assign rr_ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDW'(1);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == IDW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Completion: flags from the first RUN cycle belong to the previous
    // job, so they only count once the counter has left zero.
    // ------------------------------------------------------------------
    logic run_done;
    logic run_timeout;

    assign run_done    = (core_out_ready == 8'hFF) && (run_cnt_reg != '0);
    assign run_timeout = (run_cnt_reg == TIMEOUT_C);

    // Job FSM with all outputs registered; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            run_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            rr_ptr_reg    <= '0;
            gnt           <= '0;
            sel           <= '0;
            core_in_ready <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_any) begin
                        gnt           <= pick_onehot;
                        sel           <= pick_idx;
                        rsp_id        <= pick_idx;
                        rr_ptr_reg    <= rr_ptr_next;
                        run_cnt_reg   <= '0;
                        core_in_ready <= 1'b1;
                        busy          <= 1'b1;
                        state_reg     <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (run_done) begin
                        // Completion has priority over a coincident timeout.
                        rsp_data      <= core_out;
                        rsp_err       <= 1'b0;
                        core_in_ready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state_reg     <= S_RESP;
                    end else if (run_timeout) begin
                        rsp_data      <= {DW{1'b0}};
                        rsp_err       <= 1'b1;
                        core_in_ready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        run_cnt_reg   <= run_cnt_reg + CW'(1);
                    end
                end

                S_RESP: begin
                    // Response fields hold until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        gnt         <= '0;
                        gap_cnt_reg <= GAP_LOAD;
                        state_reg   <= S_GAP;
                    end
                end

                S_GAP: begin
                    // in_ready stays low for GAP cycles so the core can settle.
                    if (gap_cnt_reg == '0) begin
                        busy      <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_run_ctrl.sv
// Testbench for gnn_run_ctrl: directed jobs against a small core model.
// Expected responses and RUN lengths go into queues when a job is issued;
// independent monitors pop and compare when the DUT presents them.
module tb_gnn_run_ctrl;

    localparam int N_REQ = 4;
    localparam int OUT_W = 21;
    localparam int DW    = 8 * OUT_W;
    localparam int IDW   = 2;

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   gnt;
    logic [IDW-1:0]     sel;
    logic               core_in_ready;
    logic [7:0]         core_out_ready;
    logic [DW-1:0]      core_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;

    gnn_run_ctrl #(
        .N_REQ   (N_REQ),
        .OUT_W   (OUT_W),
        .TIMEOUT (31),
        .GAP     (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .gnt            (gnt),
        .sel            (sel),
        .core_in_ready  (core_in_ready),
        .core_out_ready (core_out_ready),
        .core_out       (core_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [DW-1:0]  data;
        logic           err;
    } rsp_t;

    rsp_t exp_q[$];
    int   exp_run_q[$];
    int   gap_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req_val);
        n_checks++;
        if (act !== req_val) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req_val);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event required event within budget", name);
    endtask

    // Slice k = k+100 for k<7, slice 7 = -5.
    function automatic logic [DW-1:0] pat_a();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < 7; k++) d[k*OUT_W +: OUT_W] = OUT_W'(k + 100);
        d[7*OUT_W +: OUT_W] = 21'h1FFFFB;
        return d;
    endfunction

    // Slice k = 0x100000 | (3k+1): all negative, distinct per slice.
    function automatic logic [DW-1:0] pat_b();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[k*OUT_W +: OUT_W] = 21'h100000 | OUT_W'(3*k + 1);
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Core model: all flags high in RUN cycle 0 (stale) and in cycle
    // done_at; otherwise the flags show 'stuck'.
    // ------------------------------------------------------------------
    int            done_at = 3;
    logic [7:0]    stuck   = 8'h00;
    logic [DW-1:0] core_data;

    assign core_out = core_data;

    initial begin
        int   rc;
        logic prev_cir;
        rc = -1;
        prev_cir = 1'b0;
        core_out_ready = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (core_in_ready) rc = prev_cir ? rc + 1 : 0;
            else               rc = -1;
            prev_cir = core_in_ready;
            core_out_ready = (core_in_ready && (rc == 0 || rc == done_at)) ? 8'hFF : stuck;
        end
    end

    // Response monitor: pops one expectation per handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp  id=%0d err=%0b data=%0h", rsp_id, rsp_err, rsp_data);
                    chk("rsp_id",   rsp_id,   e.id);
                    chk("rsp_gnt",  gnt,      32'(1) << e.id);
                    chk("rsp_sel",  sel,      e.id);
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_err",  rsp_err,  e.err);
                end
            end
        end
    end

    // in_ready monitor: checks RUN lengths, records low gaps between jobs.
    initial begin
        int hi;
        int lo;
        bit started;
        hi = 0;
        lo = 0;
        started = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0;
                lo = 0;
                started = 0;
            end else if (core_in_ready) begin
                if (started && lo > 0) gap_q.push_back(lo);
                lo = 0;
                hi++;
                started = 1;
            end else begin
                if (hi > 0) begin
                    if (exp_run_q.size() == 0) fail_now("run_unexpected");
                    else chk("run_len", hi, exp_run_q.pop_front());
                    hi = 0;
                end
                if (started) lo++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int id, input logic [DW-1:0] d, input logic err, input int run_len);
        rsp_t e;
        e.id = id;
        e.data = d;
        e.err = err;
        exp_q.push_back(e);
        exp_run_q.push_back(run_len);
    endtask

    task automatic wait_gnt(input logic [N_REQ-1:0] want, input int budget);
        int k;
        k = 0;
        while (gnt !== want && k < budget) begin
            tick();
            k++;
        end
        if (gnt !== want) fail_now("grant_wait");
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0 || exp_run_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        if (busy !== 1'b0 || exp_q.size() != 0 || exp_run_q.size() != 0) fail_now("idle_wait");
    endtask

    initial begin
        int k;
        rst = 1'b1;
        req = 4'hF;
        rsp_ready = 1'b1;
        core_data = pat_a();

        // Reset with all requests pending: nothing may be granted.
        repeat (3) begin
            tick();
            chk("reset_cir", core_in_ready, 1'b0);
        end
        chk("reset_gnt",  gnt,       '0);
        chk("reset_sel",  sel,       '0);
        chk("reset_rspv", rsp_valid, 1'b0);
        chk("reset_id",   rsp_id,    '0);
        chk("reset_data", rsp_data,  '0);
        chk("reset_err",  rsp_err,   1'b0);
        chk("reset_busy", busy,      1'b0);

        // Round-robin with all requests held: 0,1,2,3,0.
        push_job(0, pat_a(), 1'b0, 4);
        push_job(1, pat_a(), 1'b0, 4);
        push_job(2, pat_a(), 1'b0, 4);
        push_job(3, pat_a(), 1'b0, 4);
        push_job(0, pat_a(), 1'b0, 4);
        rst = 1'b0;
        wait_gnt(4'b0001, 10);
        tick();
        gap_q.delete();
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        req = 4'h0;
        wait_idle(50);
        chk("rr_gap_count", gap_q.size(), 4);
        foreach (gap_q[i]) chk("rr_gap_len", gap_q[i], 7);

        // Single job on requester 2; stale flags in cycle 0 are ignored.
        done_at = 3;
        push_job(2, pat_a(), 1'b0, 4);
        req = 4'b0100;
        wait_gnt(4'b0100, 20);
        chk("single_sel", sel, 2);
        chk("single_cir", core_in_ready, 1'b1);
        req = 4'h0;
        wait_idle(50);

        // Timeout: flags stuck at DF, RUN lasts 32 cycles, data cleared.
        done_at = -1;
        stuck = 8'hDF;
        push_job(0, '0, 1'b1, 32);
        req = 4'b0001;
        wait_gnt(4'b0001, 20);
        req = 4'h0;
        wait_idle(100);

        // Next job on requester 1 completes normally.
        stuck = 8'h00;
        done_at = 5;
        core_data = pat_b();
        push_job(1, pat_b(), 1'b0, 6);
        req = 4'b0010;
        wait_gnt(4'b0010, 20);
        req = 4'h0;
        wait_idle(50);

        // Backpressure: response held for 10 cycles while core data changes.
        done_at = 1;
        core_data = pat_a();
        rsp_ready = 1'b0;
        push_job(0, pat_a(), 1'b0, 2);
        push_job(1, pat_b(), 1'b0, 2);
        req = 4'b0011;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        if (rsp_valid !== 1'b1) fail_now("bp_valid_wait");
        core_data = pat_b();
        repeat (10) begin
            chk("bp_valid", rsp_valid,     1'b1);
            chk("bp_data",  rsp_data,      pat_a());
            chk("bp_cir",   core_in_ready, 1'b0);
            chk("bp_gnt",   gnt,           4'b0001);
            chk("bp_id",    rsp_id,        0);
            tick();
        end
        rsp_ready = 1'b1;
        wait_gnt(4'b0010, 30);
        req = 4'h0;
        wait_idle(50);

        // Reset in RUN cycle 2 drops in_ready and gnt immediately.
        done_at = -1;
        req = 4'b0100;
        wait_gnt(4'b0100, 20);
        req = 4'h0;
        tick();
        tick();
        chk("mid_pre_cir", core_in_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_cir",  core_in_ready, 1'b0);
        chk("mid_gnt",  gnt,           '0);
        chk("mid_busy", busy,          1'b0);
        chk("mid_rspv", rsp_valid,     1'b0);
        tick();
        tick();
        req = 4'b1000;
        rst = 1'b0;
        done_at = 3;
        core_data = pat_a();
        push_job(3, pat_a(), 1'b0, 4);
        wait_gnt(4'b1000, 20);
        chk("post_rst_sel", sel, 3);
        req = 4'h0;
        wait_idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
